ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Next-generation PS/2 device-to-host receiver: glitch-filtered ps2c, 11-bit frame capture,
//  start/parity/stop checking, and a FIFO of validated bytes.
//  Sits between the PS/2 pins (keyboard/mouse) and the scan-code decoder, which pops
//  bytes at its own pace instead of having to catch a single-cycle tick.
// PARAMETERS
//  FILTER_LEN   8      ps2c filter length; level accepted after FILTER_LEN equal samples (>=2)
//  DEPTH        4      FIFO depth in bytes, power of 2 (>=2)
//  TIMEOUT_CYC  50000  clk cycles without a falling edge mid-frame before abort (1 ms @ 50 MHz)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  ps2d         in   1   PS/2 data pin (asynchronous)
//  ps2c         in   1   PS/2 clock pin (asynchronous)
//  rx_en        in   1   1 = a new frame may start; sampled only in IDLE
//  rd_en        in   1   pop head byte; ignored when rx_valid=0
//  dout         out  8   head-of-FIFO byte (first-word fall-through); don't-care when empty
//  rx_valid     out  1   FIFO not empty
//  count        out  $clog2(DEPTH)+1  bytes held
//  parity_err   out  1   1-cycle pulse: frame dropped, odd parity failed
//  frame_err    out  1   1-cycle pulse: frame dropped, start!=0 or stop!=1
//  overflow     out  1   1-cycle pulse: good frame dropped, FIFO full
//  timeout_tick out  1   1-cycle pulse: partial frame aborted
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, filter reg all-ones, filtered ps2c = 1
//   (no false edge on release); bit counter and shift reg 0. Reset mid-frame discards it.
//  Input: ps2d and ps2c each pass a 2-flop synchroniser. ps2c then feeds a FILTER_LEN shift
//   reg. f_ps2c -> 1 when all ones, -> 0 when all zeros, else holds.
//   fall_edge = f_ps2c_reg & ~f_ps2c_next.
//  FSM states: IDLE, DPS, CHECK.
//   IDLE : fall_edge & rx_en -> shift ps2d (start bit) into 11-bit reg, n=9, -> DPS.
//          fall_edge with rx_en=0 is ignored.
//   DPS  : each fall_edge shifts ps2d in LSB-first; n==0 on edge -> CHECK, else n--.
//          rx_en deassert here does not abort the frame.
//   CHECK: one cycle; frame = {stop,par,d[7:0],start}, -> IDLE.
//     Evaluate in this priority order (exactly one outcome per frame):
//     start!=0 | stop!=1       -> frame_err.
//     else ^{d,par}==0         -> parity_err.
//     else FIFO full & !rd_en  -> overflow.
//     else push d.
//  Latency: 11th fall_edge in cycle T; CHECK in T+1; rx_valid/count/dout updated in T+2.
//  FIFO: registered wr/rd pointers ($clog2(DEPTH) bits, natural wrap) plus count.
//   Pop when rd_en & rx_valid. Push & pop in the same cycle: count unchanged, including
//   when full (push accepted, no overflow). Pop when empty: no effect, count stays 0.
//  Pulses (err/overflow/timeout) are registered, high exactly one cycle, never together.
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined:
//   - A cycle counter clears on every fall_edge and on entry to DPS, and counts while in DPS.
//   - Reaching TIMEOUT_CYC-1 -> IDLE, shift reg/n cleared, timeout_tick pulse, nothing pushed.
//  Not defined:
//   - No counter; timeout_tick tied 0; DPS waits indefinitely for edges.
// STRUCTURE
//  Shared package/include ps2_pkg:
//   - FSM state encodings (IDLE=2'b00, DPS=2'b01, CHECK=2'b10).
//   - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
//   - Function ps2_odd_parity_ok(d, p).
//  One sub-module: ps2_clk_filter (synchroniser + FILTER_LEN filter; outputs f_ps2c, fall_edge).
//  FSM, shift reg and FIFO are inline in this module.
// TESTING (bench: 50 MHz clk, FILTER_LEN=8, DEPTH=4, TIMEOUT_CYC=2000, ps2c half-period 400 clk)
//  1 Frame 0x1C, par=0, stop=1, rx_en=1 -> rx_valid=1, dout=0x1C, count=1 at T+2; rd_en 1 cycle -> count=0.
//  2 Frame 0x1C with par=1 -> parity_err single pulse; count stays 0. Same byte with stop=0 -> frame_err only.
//  3 Frames 0x01..0x05, no reads -> overflow on 5th; pops return 01,02,03,04. Then 6th frame with rd_en in CHECK cycle -> pushed, count=4.
//  4 ps2c low glitch of 7 clk (<FILTER_LEN) in IDLE and in DPS -> no fall_edge, no bit shifted, frame still decodes.
//  5 (PS2_RX_TIMEOUT_EN) 5 edges then silence -> timeout_tick at 2000 clk after last edge; next frame 0xF0 received intact.
//  6 reset asserted 1 cycle after 6th edge -> outputs/FIFO cleared; following frame 0xAA received, count=1; rx_en=0 frame ignored.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM encoding, frame geometry and the parity helper.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DPS   = 2'b01,
        CHECK = 2'b10
    } ps2_state_e;

    // A PS/2 byte plus its parity bit must contain an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                               input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2c synchroniser and FILTER_LEN-sample glitch filter; emits the filtered level and a
// one-cycle pulse on each accepted falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic f_ps2c,
    output logic fall_edge
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  f_q, f_d;

    // Everything resets high so releasing reset with ps2c idle cannot fake an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            filt_q <= '1;
            f_q    <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], ps2c};
            filt_q <= filt_d;
            f_q    <= f_d;
        end
    end

    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], sync_q[1]};
        f_d    = f_q;
        if (&filt_d) begin
            f_d = 1'b1;
        end else if (~|filt_d) begin
            f_d = 1'b0;
        end
    end

    assign f_ps2c    = f_q;
    assign fall_edge = f_q & ~f_d;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checking and a first-word-fall-through byte FIFO.
// Define PS2_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2d,
    input  logic                     ps2c,
    input  logic                     rx_en,
    input  logic                     rd_en,
    output logic [PS2_DATA_BITS-1:0] dout,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overflow,
    output logic                     timeout_tick
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [1:0]                d_sync_q;
    logic                      d_s;
    logic                      fall_edge;
    ps2_state_e                state_q, state_d;
    logic [PS2_FRAME_BITS-1:0] sh_q, sh_d;
    logic [3:0]                n_q, n_d;
    logic                      perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic                      push, pop, full;
    logic [PS2_DATA_BITS-1:0]  mem [DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [AW:0]               count_q, count_d;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .f_ps2c    (),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            d_sync_q <= 2'b11;
        end else begin
            d_sync_q <= {d_sync_q[0], ps2d};
        end
    end
    assign d_s = d_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int          TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_q, to_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
        end
    end
    assign timeout_tick = to_q;
`else
    assign timeout_tick = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Bits arrive LSB first, so they enter at the top and drift down to sh_q[0].
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        n_d     = n_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovf_d   = 1'b0;
        push    = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall_edge && rx_en) begin
                    sh_d    = {d_s, sh_q[PS2_FRAME_BITS-1:1]};
                    n_d     = 4'd9;
                    state_d = DPS;
`ifdef PS2_RX_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            DPS: begin
                if (fall_edge) begin
                    sh_d = {d_s, sh_q[PS2_FRAME_BITS-1:1]};
                    if (n_q == 4'd0) begin
                        state_d = CHECK;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
`ifdef PS2_RX_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    sh_d    = '0;
                    n_d     = '0;
                    to_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
`endif
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (sh_q[0] || !sh_q[PS2_FRAME_BITS-1]) begin
                    ferr_d = 1'b1;
                end else if (!ps2_odd_parity_ok(sh_q[8:1], sh_q[9])) begin
                    perr_d = 1'b1;
                end else if (full && !rd_en) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the push cycle frees the slot, so a full FIFO still accepts the byte.
    assign pop  = rd_en && (count_q != '0);
    assign full = (count_q == FULL_CNT);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sh_q[8:1];
        end
    end

    assign rx_valid   = (count_q != '0);
    assign count      = count_q;
    assign dout       = rx_valid ? mem[rd_ptr_q] : '0;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frame-level reference model plus directed and random frames.
module tb_ps2_rx_fifo;

    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b0;
    logic       rd_en;
    logic       rd_man = 1'b0;
    logic       rd_rnd = 1'b0;
    logic       rd_rand = 1'b0;
    logic [7:0] dout;
    logic       rx_valid;
    logic [2:0] count;
    logic       parity_err, frame_err, overflow, timeout_tick;

    assign rd_en = rd_rand ? rd_rnd : rd_man;

    ps2_rx_fifo #(.FILTER_LEN(FL), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .rx_valid     (rx_valid),
        .count        (count),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .timeout_tick (timeout_tick)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rd_rnd = ($urandom_range(0, 15) == 0);
    end

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0, n_to = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: accepted ps2c falls are known from the stimulus (sync + filter delay),
    // everything else follows the frame rules directly.
    logic [7:0]  q[$];
    int          e_cyc[$];
    bit          e_bit[$];
    bit          m_busy = 0, m_check = 0;
    logic [10:0] m_bits = '0;
    int          m_n = 0, m_last = 0;
    bit          x_perr = 0, x_ferr = 0, x_ovf = 0, x_to = 0;

    always @(negedge clk) begin : model
        bit         e_now, eb, pop, push;
        logic [7:0] pd;
        if (chk_en) begin
            check("count", count, q.size());
            check("rx_valid", rx_valid, q.size() != 0);
            if (q.size() != 0) check("dout", dout, q[0]);
            check("parity_err", parity_err, x_perr);
            check("frame_err", frame_err, x_ferr);
            check("overflow", overflow, x_ovf);
            check("timeout_tick", timeout_tick, x_to);
            check("pulse_exclusive", $countones({parity_err, frame_err, overflow, timeout_tick}) <= 1, 1);
            n_perr += int'(parity_err);
            n_ferr += int'(frame_err);
            n_ovf  += int'(overflow);
            n_to   += int'(timeout_tick);
        end
        e_now = 0; eb = 0; push = 0; pd = '0;
        if (e_cyc.size() != 0 && e_cyc[0] == cyc) begin
            e_now = 1;
            eb    = e_bit[0];
            void'(e_cyc.pop_front());
            void'(e_bit.pop_front());
        end
        x_perr = 0; x_ferr = 0; x_ovf = 0; x_to = 0;
        if (reset) begin
            q.delete();
            m_busy = 0; m_check = 0; m_n = 0;
        end else begin
            pop = rd_en && (q.size() != 0);
            if (m_check) begin
                m_check = 0;
                pd = m_bits[8:1];
                if (m_bits[0] != 1'b0 || m_bits[10] != 1'b1) x_ferr = 1;
                else if ((^m_bits[9:1]) == 1'b0)             x_perr = 1;
                else if (q.size() == DEPTH && !rd_en)          x_ovf = 1;
                else                                           push = 1;
            end else if (e_now) begin
                if (!m_busy) begin
                    if (rx_en) begin
                        m_busy = 1; m_bits[0] = eb; m_n = 1; m_last = cyc;
                    end
                end else begin
                    m_bits[m_n] = eb; m_n++; m_last = cyc;
                    if (m_n == 11) begin
                        m_busy = 0; m_check = 1;
                    end
                end
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (m_busy && (cyc - m_last) == TO) begin
                m_busy = 0; x_to = 1;
            end
`endif
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(pd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par,
                                       input bit st, input bit sp);
        return {sp, (~^d) ^ bad_par, d, st};
    endfunction

    // Drives nb bits LSB first; optional 7-clk low glitch in the high phase before bit glitch_at.
    task automatic send_bits(input logic [10:0] b, input int nb, input int hp,
                             input int glitch_at, input bit rd_in_check);
        for (int i = 0; i < nb; i++) begin
            ps2d = b[i];
            if (i == glitch_at) begin
                step(hp / 2); ps2c = 0; step(FL - 1); ps2c = 1; step(hp - hp / 2 - (FL - 1));
            end else begin
                step(hp);
            end
            ps2c = 0;
            e_cyc.push_back(cyc + FL + 1);
            e_bit.push_back(b[i]);
            if (rd_in_check && i == nb - 1) begin
                step(FL + 2); rd_man = 1; step(1); rd_man = 0; step(hp - FL - 3);
            end else begin
                step(hp);
            end
            ps2c = 1;
        end
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, dout, exp);
        step(1); rd_man = 1; step(1); rd_man = 0;
    endtask

    task automatic drain();
        rd_man = 1; step(DEPTH + 2); rd_man = 0; step(1);
        @(negedge clk);
        check("drain_count", count, 0);
        step(1);
    endtask

    initial begin : stim
        int p0, f0, o0, t0;
        logic [10:0] f;
        step(2);
        chk_en = 1;
        step(3);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_valid", rx_valid, 0);
        step(1);
        reset = 0;
        rx_en = 1;
        step(10);

        // 1: good frame 0x1C, then a single pop
        send_bits(mk(8'h1C, 0, 0, 1), 11, 400, -1, 0);
        @(negedge clk);
        check("t1_dout", dout, 8'h1C);
        check("t1_count", count, 1);
        step(1); rd_man = 1; step(1); rd_man = 0;
        @(negedge clk);
        check("t1_count_after_pop", count, 0);
        step(1);

        // 2: parity error, then stop-bit error
        p0 = n_perr; f0 = n_ferr;
        send_bits(mk(8'h1C, 1, 0, 1), 11, 400, -1, 0);
        step(2);
        check("t2_perr_pulses", n_perr - p0, 1);
        check("t2_perr_count", count, 0);
        p0 = n_perr;
        send_bits(mk(8'h1C, 0, 0, 0), 11, 400, -1, 0);
        step(2);
        check("t2_ferr_pulses", n_ferr - f0, 1);
        check("t2_ferr_no_perr", n_perr - p0, 0);

        // 3: overflow on the fifth frame, FIFO order, push+pop while full
        o0 = n_ovf;
        for (int k = 1; k <= 5; k++) send_bits(mk(8'(k), 0, 0, 1), 11, 50, -1, 0);
        step(2);
        check("t3_ovf_pulses", n_ovf - o0, 1);
        check("t3_full_count", count, 4);
        for (int k = 1; k <= 4; k++) pop_expect("t3_pop", 8'(k));
        for (int k = 1; k <= 4; k++) send_bits(mk(8'(8'h10 + k), 0, 0, 1), 11, 50, -1, 0);
        o0 = n_ovf;
        send_bits(mk(8'h15, 0, 0, 1), 11, 50, -1, 1);
        step(2);
        @(negedge clk);
        check("t3_pushpop_count", count, 4);
        check("t3_pushpop_head", dout, 8'h12);
        check("t3_pushpop_no_ovf", n_ovf - o0, 0);
        step(1);
        drain();

        // 4: sub-filter glitches in IDLE and mid-frame
        send_bits(mk(8'h5A, 0, 0, 1), 11, 50, 0, 0);
        send_bits(mk(8'h3C, 0, 0, 1), 11, 50, 5, 0);
        @(negedge clk);
        check("t4_count", count, 2);
        pop_expect("t4_glitch_idle", 8'h5A);
        pop_expect("t4_glitch_dps", 8'h3C);
        drain();

`ifdef PS2_RX_TIMEOUT_EN
        // 5: partial frame abort, then a clean frame
        t0 = n_to;
        send_bits(mk(8'h77, 0, 0, 1), 5, 50, -1, 0);
        step(TO + 30);
        check("t5_timeout_pulses", n_to - t0, 1);
        check("t5_count", count, 0);
        send_bits(mk(8'hF0, 0, 0, 1), 11, 50, -1, 0);
        @(negedge clk);
        check("t5_dout", dout, 8'hF0);
        step(1);
        drain();
`else
        t0 = n_to;
        send_bits(mk(8'h77, 0, 0, 1), 5, 50, -1, 0);
        step(TO + 30);
        check("t5_no_timeout", n_to - t0, 0);
        send_bits(mk(8'h77, 0, 0, 1) >> 5, 6, 50, -1, 0);
        @(negedge clk);
        check("t5_resumed_dout", dout, 8'h77);
        step(1);
        drain();
`endif

        // 6: reset mid-frame clears everything; rx_en=0 frames are ignored
        send_bits(mk(8'h99, 0, 0, 1), 11, 50, -1, 0);
        f = mk(8'h42, 0, 0, 1);
        send_bits(f, 5, 50, -1, 0);
        ps2d = f[5];
        step(50);
        ps2c = 0;
        e_cyc.push_back(cyc + FL + 1);
        e_bit.push_back(f[5]);
        step(FL + 2);
        reset = 1; rx_en = 0;
        step(1);
        reset = 0;
        @(negedge clk);
        check("t6_reset_count", count, 0);
        check("t6_reset_valid", rx_valid, 0);
        step(1);
        step(50 - FL - 4);
        ps2c = 1;
        send_bits(f >> 6, 5, 50, -1, 0);
        step(20);
        rx_en = 1;
        send_bits(mk(8'hAA, 0, 0, 1), 11, 50, -1, 0);
        @(negedge clk);
        check("t6_aa_count", count, 1);
        check("t6_aa_dout", dout, 8'hAA);
        step(1);
        rx_en = 0;
        send_bits(mk(8'h55, 0, 0, 1), 11, 50, -1, 0);
        @(negedge clk);
        check("t6_ignored_count", count, 1);
        step(1);
        drain();

        // Random frames with random errors and random reads
        rx_en = 1;
        rd_rand = 1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            int kind;
            d = 8'($urandom);
            kind = $urandom_range(0, 7);
            send_bits(mk(d, kind == 0, kind == 2, kind != 1), 11, $urandom_range(20, 60), -1, 0);
        end
        rd_rand = 0;
        step(2);
        drain();

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
